// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: widths, register indices and common types.
// Imported by the register file, the operand mux and the ALU.
package cpu_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int REG_COUNT = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero-index override, write-first bypass and
// an output register that holds its value while re is low.
module regfile_read_port
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     re,
    input  reg_idx_t raddr,
    input  word_t    stored,
    input  logic     we,
    input  reg_idx_t waddr,
    input  word_t    wdata,
    output word_t    rdata
);

    word_t next_rdata;

    // Index 0 wins over the bypass, so a write to r0 can never leak out.
    always_comb begin
        next_rdata = stored;
        if (raddr == ZERO_REG)
            next_rdata = '0;
        else if (we && (waddr == raddr))
            next_rdata = wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= next_rdata;
    end

endmodule

// File: rtl/register_file.sv
// Eight-entry flip-flop register file with two registered read ports and
// one write port; r0 is hardwired to zero.
module register_file
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     we,
    input  reg_idx_t waddr,
    input  word_t    wdata,
    input  logic     re,
    input  reg_idx_t raddr_a,
    input  reg_idx_t raddr_b,
    output word_t    rdata_a,
    output word_t    rdata_b
);

    word_t mem [REG_COUNT];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                mem[i] <= '0;
        end else if (we && (waddr != ZERO_REG)) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_read_port u_port_a (
        .clk    (clk),
        .rst    (rst),
        .re     (re),
        .raddr  (raddr_a),
        .stored (mem[raddr_a]),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata_a)
    );

    regfile_read_port u_port_b (
        .clk    (clk),
        .rst    (rst),
        .re     (re),
        .raddr  (raddr_b),
        .stored (mem[raddr_b]),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdata  (rdata_b)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference model predicts each
// cycle's outputs into a scoreboard queue, checked one edge later.
module tb_register_file;
    import cpu_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     we;
    logic     re;
    reg_idx_t waddr;
    reg_idx_t raddr_a;
    reg_idx_t raddr_b;
    word_t    wdata;
    word_t    rdata_a;
    word_t    rdata_b;

    register_file dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t a;
        word_t b;
    } exp_t;

    exp_t  sbq[$];
    word_t mdl [REG_COUNT];
    word_t hold_a;
    word_t hold_b;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_COUNT; i++)
            mdl[i] = '0;
        hold_a = '0;
        hold_b = '0;
    endtask

    function automatic word_t next_rd(input reg_idx_t ra, input word_t hold);
        if (rst)                   return '0;
        if (!re)                   return hold;
        if (ra == ZERO_REG)        return '0;
        if (we && (waddr == ra))   return wdata;
        return mdl[ra];
    endfunction

    // Drive one cycle, push the predicted outputs, then check them after the edge.
    task automatic cycle(input string tag, input logic w, input reg_idx_t wa, input word_t wd,
                         input logic r, input reg_idx_t ra, input reg_idx_t rb);
        exp_t e;
        we = w; waddr = wa; wdata = wd; re = r; raddr_a = ra; raddr_b = rb;
        e.a = next_rd(ra, hold_a);
        e.b = next_rd(rb, hold_b);
        if (!rst && w && (wa != ZERO_REG))
            mdl[wa] = wd;
        hold_a = e.a;
        hold_b = e.b;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({tag, "_sb_a"}, rdata_a, e.a);
        chk({tag, "_sb_b"}, rdata_b, e.b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0;
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        model_reset();
        #12;
        chk("por_a", rdata_a, 16'h0000);
        chk("por_b", rdata_b, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset clear, including an in-flight write held across an edge in reset.
        cycle("w_r3", 1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 3'd3);
        chk("pre_rst_a", rdata_a, 16'h1234);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_now_a", rdata_a, 16'h0000);
        chk("rst_now_b", rdata_b, 16'h0000);
        cycle("in_rst", 1'b1, 3'd6, 16'hDEAD, 1'b1, 3'd6, 3'd3);
        rst = 1'b0;
        cycle("post_rst", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd6);
        chk("r3_after_rst", rdata_a, 16'h0000);
        chk("r6_after_rst", rdata_b, 16'h0000);

        // Basic write then read
        cycle("w_r5", 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd0);
        cycle("r_r5", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd5);
        chk("r5_a", rdata_a, 16'hBEEF);
        chk("r5_b", rdata_b, 16'hBEEF);
        cycle("w_r1", 1'b1, 3'd1, 16'h0001, 1'b0, 3'd0, 3'd0);
        cycle("w_r2", 1'b1, 3'd2, 16'h0002, 1'b0, 3'd0, 3'd0);
        cycle("r_r12", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd2);
        chk("r1_a", rdata_a, 16'h0001);
        chk("r2_b", rdata_b, 16'h0002);

        // Zero register
        cycle("w_r0", 1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 3'd0);
        cycle("r_r0", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0);
        chk("r0_a", rdata_a, 16'h0000);
        cycle("byp_r0", 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0);
        chk("r0_bypass_a", rdata_a, 16'h0000);

        // Write-first bypass
        cycle("w_r4", 1'b1, 3'd4, 16'h1111, 1'b0, 3'd0, 3'd0);
        cycle("byp_r4", 1'b1, 3'd4, 16'h0A5A, 1'b1, 3'd4, 3'd4);
        chk("bypass_a", rdata_a, 16'h0A5A);
        chk("bypass_b", rdata_b, 16'h0A5A);

        // Stall holds outputs while writes continue
        cycle("pre_stall", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd2);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 3'd1, 16'h7777, 1'b0, 3'd5, 3'd4);
            chk("stall_a", rdata_a, 16'h0001);
            chk("stall_b", rdata_b, 16'h0002);
        end
        cycle("post_stall", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1);
        chk("post_stall_a", rdata_a, 16'h7777);

        // Exhaustive sweep
        for (int i = 1; i < REG_COUNT; i++)
            cycle("sweep_w", 1'b1, reg_idx_t'(i), word_t'(16'h1000 + i), 1'b0, 3'd0, 3'd0);
        for (int a = 0; a < REG_COUNT; a++) begin
            for (int b = 0; b < REG_COUNT; b++) begin
                cycle("sweep_r", 1'b0, 3'd0, 16'h0000, 1'b1, reg_idx_t'(a), reg_idx_t'(b));
                chk("sweep_a", rdata_a, (a == 0) ? 16'h0000 : word_t'(16'h1000 + a));
                chk("sweep_b", rdata_b, (b == 0) ? 16'h0000 : word_t'(16'h1000 + b));
            end
        end

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            cycle("rand", 1'($urandom_range(0, 1)), reg_idx_t'($urandom_range(0, 7)),
                  word_t'($urandom), 1'($urandom_range(0, 3) != 0),
                  reg_idx_t'($urandom_range(0, 7)), reg_idx_t'($urandom_range(0, 7)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
